// File: rtl/lift_input_conditioner_if.sv
// Bundle between the raw car/shaft lines and the lift controller's conditioned inputs.
// Every signal is point-to-point and has no handshake: the conditioner never stalls its source.
interface lift_input_conditioner_if #(
    parameter int N = 14
);
    logic [N-1:0] raw_x;
    logic         clr_glitch;
    logic [N-1:0] x_out;
    logic [N-1:0] x_chg;
    logic         settled;
    logic [7:0]   glitch_cnt;

    modport master (
        output raw_x,
        output clr_glitch,
        input  x_out,
        input  x_chg,
        input  settled,
        input  glitch_cnt
    );

    modport slave (
        input  raw_x,
        input  clr_glitch,
        output x_out,
        output x_chg,
        output settled,
        output glitch_cnt
    );
endinterface

// File: rtl/lift_input_conditioner.sv
// Synchronises and debounces the raw lift lines into x1..x14. A change reaches x_out after DEBOUNCE+1 edges, or 2 for bypassed lines.
// No backpressure: the block accepts a new raw sample every cycle, and all outputs are registered.
module lift_input_conditioner #(
    parameter int           N           = 14,
    parameter int           DEBOUNCE    = 4,
    parameter int           CNT_W       = 8,
    parameter logic [N-1:0] RST_VAL     = '0,
    parameter logic [N-1:0] BYPASS_MASK = '0
) (
    input logic                  clk,
    input logic                  rst,
    lift_input_conditioner_if.slave io
);
    localparam int RW = $clog2(N + 1);
    localparam int GW = 8 + RW;

    logic [N-1:0]     sync1, sync2;
    logic [N-1:0]     x_q, x_d;
    logic [N-1:0]     chg_q, chg_d;
    logic [N-1:0]     rej;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [7:0]       glitch_q, glitch_d;
    logic             settled_q, settled_d;
    logic [RW-1:0]    nrej;
    logic [GW-1:0]    gsum;

    always_comb begin
        x_d   = x_q;
        chg_d = '0;
        rej   = '0;
        cnt_d = '{default: '0};
        for (int i = 0; i < N; i++) begin
            if (BYPASS_MASK[i]) begin
                x_d[i]   = sync2[i];
                chg_d[i] = sync2[i] ^ x_q[i];
            end else if (sync2[i] == x_q[i]) begin
                // A partial run that falls back to the old value is a rejected glitch.
                rej[i] = (cnt_q[i] != '0);
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
                x_d[i]   = sync2[i];
                chg_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        nrej = '0;
        for (int i = 0; i < N; i++) begin
            nrej = nrej + RW'(rej[i]);
        end
        gsum = GW'(glitch_q) + GW'(nrej);
        if (io.clr_glitch) begin
            glitch_d = '0;
        end else if (gsum > GW'(255)) begin
            glitch_d = 8'hFF;
        end else begin
            glitch_d = gsum[7:0];
        end
        settled_d = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (cnt_d[i] != '0) begin
                settled_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= RST_VAL;
            sync2     <= RST_VAL;
            x_q       <= RST_VAL;
            chg_q     <= '0;
            glitch_q  <= '0;
            settled_q <= 1'b1;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1     <= io.raw_x;
            sync2     <= sync1;
            x_q       <= x_d;
            chg_q     <= chg_d;
            glitch_q  <= glitch_d;
            settled_q <= settled_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io.x_out      = x_q;
    assign io.x_chg      = chg_q;
    assign io.settled    = settled_q;
    assign io.glitch_cnt = glitch_q;
endmodule
